// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_if
// Purpose  : Bundles the pipeline writeback request, the multi-cycle result
//            handshake and the register-file write port seen by the
//            writeback arbiter.
// Ports    : master - driven by the sources (pipeline / multi-cycle unit),
//                     observes stall, ready, init status and the write port
//            slave  - the arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if;
  // pipeline writeback
  logic        p_wb_en;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        stall_pipe;
  // multi-cycle unit (valid/ready)
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  // status and register-file write port
  logic        init_done;
  logic        rf_wb_en;
  logic [4:0]  rf_rd_index;
  logic [31:0] rf_wb_data;

  modport master (
    output p_wb_en, p_rd, p_data, m_valid, m_rd, m_data,
    input  stall_pipe, m_ready, init_done, rf_wb_en, rf_rd_index, rf_wb_data
  );

  modport slave (
    input  p_wb_en, p_rd, p_data, m_valid, m_rd, m_data,
    output stall_pipe, m_ready, init_done, rf_wb_en, rf_rd_index, rf_wb_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Owns the single register-file write port. After reset it sweeps
//            zeros into every register, then shares the port between the
//            in-order pipeline writeback (priority) and results of the
//            multi-cycle unit, which are buffered in a small FIFO. A FIFO
//            entry left waiting too long forces a one-cycle drain that stalls
//            the pipeline.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            bus (slave)   - p_* pipeline request, stall_pipe,
//                            m_* valid/ready result input,
//                            init_done, rf_* registered write port
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_REGS     = 32
) (
  input wire           clk,
  input wire           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] c_ST_INIT  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  localparam logic [4:0]         c_LAST_IDX    = 5'(NUM_REGS - 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_LAST = c_CNT_W'(STARVE_LIMIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_PTR_W:0]   c_PTR_ONE     = (c_PTR_W + 1)'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [4:0]         r_idx;
  logic [c_PTR_W:0]   r_wr_ptr;
  logic [c_PTR_W:0]   r_rd_ptr;
  logic [4:0]         r_mem_rd   [FIFO_DEPTH];
  logic [31:0]        r_mem_data [FIFO_DEPTH];
  logic [c_CNT_W-1:0] r_starve;
  logic               r_init_done;
  logic               r_wb_en;
  logic [4:0]         r_rd_index;
  logic [31:0]        r_wb_data;

  logic               w_empty;
  logic               w_full;
  logic               w_m_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_starve_inc;
  logic               w_starve_hit;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_head_data;
  logic               w_nxt_en;
  logic [4:0]         w_nxt_index;
  logic [31:0]        w_nxt_data;
  logic               w_stall;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  // Full blocks a push even when a pop happens on the same edge.
  assign w_m_ready = r_init_done && !w_full;
  assign w_push    = bus.m_valid && w_m_ready;

  assign w_head_rd   = r_mem_rd[r_rd_ptr[c_PTR_W-1:0]];
  assign w_head_data = r_mem_data[r_rd_ptr[c_PTR_W-1:0]];

  // The pipeline wins in RUN; the FIFO is served only when it is idle,
  // and unconditionally during the forced drain.
  assign w_pop = !w_empty &&
                 (((r_state == c_ST_RUN) && !bus.p_wb_en) || (r_state == c_ST_DRAIN));
  // A waiting entry lost to the pipeline this cycle.
  assign w_starve_inc = (r_state == c_ST_RUN) && bus.p_wb_en && !w_empty;
  assign w_starve_hit = w_starve_inc && (r_starve == c_STARVE_LAST);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_INIT:  if (r_idx == c_LAST_IDX) w_next_state = c_ST_RUN;
      c_ST_RUN:   if (w_starve_hit)        w_next_state = c_ST_DRAIN;
      c_ST_DRAIN: w_next_state = c_ST_RUN;
      default:    w_next_state = c_ST_INIT;
    endcase
  end

  // -------------------------------------------------------------- output comb
  // Index and data hold whenever no write is produced, including when a
  // request or entry aimed at x0 is consumed.
  always_comb begin
    w_stall     = (r_state != c_ST_RUN);
    w_nxt_en    = 1'b0;
    w_nxt_index = r_rd_index;
    w_nxt_data  = r_wb_data;
    if (r_state == c_ST_INIT) begin
      w_nxt_en    = 1'b1;
      w_nxt_index = r_idx;
      w_nxt_data  = 32'd0;
    end else if ((r_state == c_ST_RUN) && bus.p_wb_en) begin
      if (bus.p_rd != 5'd0) begin
        w_nxt_en    = 1'b1;
        w_nxt_index = bus.p_rd;
        w_nxt_data  = bus.p_data;
      end
    end else if (w_pop) begin
      if (w_head_rd != 5'd0) begin
        w_nxt_en    = 1'b1;
        w_nxt_index = w_head_rd;
        w_nxt_data  = w_head_data;
      end
    end
  end

  // ------------------------------------------------------------ datapath regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= 5'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_starve    <= '0;
      r_init_done <= 1'b0;
      r_wb_en     <= 1'b0;
      r_rd_index  <= 5'd0;
      r_wb_data   <= 32'd0;
    end else begin
      r_wb_en    <= w_nxt_en;
      r_rd_index <= w_nxt_index;
      r_wb_data  <= w_nxt_data;
      if (r_state == c_ST_INIT) begin
        r_idx <= r_idx + 5'd1;
        if (r_idx == c_LAST_IDX) r_init_done <= 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_pop || w_starve_hit) begin
        r_starve <= '0;
      end else if (w_starve_inc) begin
        r_starve <= r_starve + c_CNT_ONE;
      end
    end
  end

  // FIFO storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr[c_PTR_W-1:0]]   <= bus.m_rd;
      r_mem_data[r_wr_ptr[c_PTR_W-1:0]] <= bus.m_data;
    end
  end

  assign bus.stall_pipe  = w_stall;
  assign bus.m_ready     = w_m_ready;
  assign bus.init_done   = r_init_done;
  assign bus.rf_wb_en    = r_wb_en;
  assign bus.rf_rd_index = r_rd_index;
  assign bus.rf_wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking bench for rf_wb_arbiter. A behavioural model
//            (sweep counter, result queue, wait counter) predicts every
//            registered output; a negedge process compares the DUT with it
//            each cycle, and directed sequences pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int NUM_REGS     = 32;

  localparam int M_SWEEP = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .NUM_REGS     (NUM_REGS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- model
  int          mode;
  int          sweep;
  int          starve;
  ent_t        mq[$];
  logic        e_done;
  logic        e_en;
  logic [4:0]  e_idx;
  logic [31:0] e_data;
  bit          known;   // index/data defined (not after an x0 consume)

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mode   = M_SWEEP;
    sweep  = 0;
    starve = 0;
    mq.delete();
    e_done = 1'b0;
    e_en   = 1'b0;
    e_idx  = 5'd0;
    e_data = 32'd0;
    known  = 1'b1;
  endtask

  task automatic model_write(input logic [4:0] rd, input logic [31:0] data);
    if (rd == 5'd0) begin
      e_en  = 1'b0;
      known = 1'b0;
    end else begin
      e_en   = 1'b1;
      e_idx  = rd;
      e_data = data;
      known  = 1'b1;
    end
  endtask

  // One clock edge of the arbiter rules, using the values visible before it.
  task automatic model_step();
    int   occ;
    bit   can_push;
    bit   do_pop;
    ent_t h;
    occ      = mq.size();
    can_push = e_done && (occ < FIFO_DEPTH);
    do_pop   = 1'b0;
    case (mode)
      M_SWEEP: begin
        e_en   = 1'b1;
        e_idx  = 5'(sweep);
        e_data = 32'd0;
        known  = 1'b1;
        if (sweep == NUM_REGS - 1) begin
          e_done = 1'b1;
          mode   = M_RUN;
        end
        sweep++;
      end
      M_RUN: begin
        if (bus.p_wb_en) begin
          model_write(bus.p_rd, bus.p_data);
          if (occ > 0) begin
            starve++;
            if (starve == STARVE_LIMIT) begin
              starve = 0;
              mode   = M_DRAIN;
            end
          end
        end else if (occ > 0) begin
          do_pop = 1'b1;
        end else begin
          e_en = 1'b0;
        end
      end
      default: begin
        do_pop = 1'b1;
        mode   = M_RUN;
      end
    endcase
    if (do_pop) begin
      h = mq.pop_front();
      model_write(h.rd, h.data);
      starve = 0;
    end
    if (can_push && bus.m_valid) mq.push_back({bus.m_rd, bus.m_data});
  endtask

  // ------------------------------------------------------- per-cycle compare
  always @(negedge clk) begin
    chk("stall_pipe", 32'(bus.stall_pipe), 32'(mode != M_RUN));
    chk("m_ready", 32'(bus.m_ready), 32'(e_done && (mq.size() < FIFO_DEPTH)));
    chk("init_done", 32'(bus.init_done), 32'(e_done));
    chk("rf_wb_en", 32'(bus.rf_wb_en), 32'(e_en));
    if (e_en || known) begin
      chk("rf_rd_index", 32'(bus.rf_rd_index), 32'(e_idx));
      chk("rf_wb_data", bus.rf_wb_data, e_data);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic step(input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] mdat);
    bus.p_wb_en = pw;
    bus.p_rd    = prd;
    bus.p_data  = pd;
    bus.m_valid = mv;
    bus.m_rd    = mrd;
    bus.m_data  = mdat;
    @(posedge clk);
    if (!rst) model_step();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_rst_en"},    32'(bus.rf_wb_en), 32'd0);
    chk({tag, "_rst_idx"},   32'(bus.rf_rd_index), 32'd0);
    chk({tag, "_rst_data"},  bus.rf_wb_data, 32'd0);
    chk({tag, "_rst_done"},  32'(bus.init_done), 32'd0);
    chk({tag, "_rst_ready"}, 32'(bus.m_ready), 32'd0);
    chk({tag, "_rst_stall"}, 32'(bus.stall_pipe), 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    reset_literals(tag);
    release_reset();
  endtask

  bit          hold;
  bit          pw;
  logic [4:0]  prd;
  logic [31:0] pd;

  initial begin
    bus.p_wb_en = 1'b0; bus.p_rd = 5'd0; bus.p_data = 32'd0;
    bus.m_valid = 1'b0; bus.m_rd = 5'd0; bus.m_data = 32'd0;
    model_reset();
    #1;
    rst = 1'b1;
    #1;
    reset_literals("por");
    release_reset();

    // Init sweep: 32 writes of zero, index 0..31; init_done with index 31.
    step(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    chk("sweep_first_idx", 32'(bus.rf_rd_index), 32'd0);
    chk("sweep_first_en", 32'(bus.rf_wb_en), 32'd1);
    idle(30);
    chk("sweep_not_done", 32'(bus.init_done), 32'd0);
    idle(1);
    chk("sweep_last_idx", 32'(bus.rf_rd_index), 32'd31);
    chk("sweep_done", 32'(bus.init_done), 32'd1);
    chk("sweep_ready", 32'(bus.m_ready), 32'd1);

    // Pipeline write.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    chk("pwr_en", 32'(bus.rf_wb_en), 32'd1);
    chk("pwr_idx", 32'(bus.rf_rd_index), 32'd5);
    chk("pwr_data", bus.rf_wb_data, 32'hDEAD_BEEF);
    idle(1);
    chk("pwr_idle_en", 32'(bus.rf_wb_en), 32'd0);

    // Multi-cycle write: pushed, then popped one edge later.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
    chk("mwr_push_en", 32'(bus.rf_wb_en), 32'd0);
    idle(1);
    chk("mwr_pop_idx", 32'(bus.rf_rd_index), 32'd7);
    chk("mwr_pop_data", bus.rf_wb_data, 32'h1234_5678);

    // Starvation: pipeline busy every cycle, one queued entry for x9.
    step(1'b1, 5'd16, 32'hA5A5_0016, 1'b1, 5'd9, 32'h0000_0909);
    step(1'b1, 5'd17, 32'hA5A5_0017, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd18, 32'hA5A5_0018, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd19, 32'hA5A5_0019, 1'b0, 5'd0, 32'd0);
    chk("starve_no_stall", 32'(bus.stall_pipe), 32'd0);
    step(1'b1, 5'd20, 32'hA5A5_0020, 1'b0, 5'd0, 32'd0);
    chk("starve_stall", 32'(bus.stall_pipe), 32'd1);
    chk("starve_p20_idx", 32'(bus.rf_rd_index), 32'd20);
    step(1'b1, 5'd21, 32'hA5A5_0021, 1'b0, 5'd0, 32'd0);
    chk("drain_idx", 32'(bus.rf_rd_index), 32'd9);
    chk("drain_data", bus.rf_wb_data, 32'h0000_0909);
    chk("drain_unstall", 32'(bus.stall_pipe), 32'd0);
    step(1'b1, 5'd21, 32'hA5A5_0021, 1'b0, 5'd0, 32'd0);
    chk("held_lands_idx", 32'(bus.rf_rd_index), 32'd21);

    // Full FIFO refuses a third entry.
    step(1'b1, 5'd11, 32'h0000_0011, 1'b1, 5'd12, 32'hC0DE_0001);
    chk("fill1_ready", 32'(bus.m_ready), 32'd1);
    step(1'b1, 5'd13, 32'h0000_0013, 1'b1, 5'd12, 32'hC0DE_0002);
    chk("fill2_ready", 32'(bus.m_ready), 32'd0);
    step(1'b1, 5'd15, 32'h0000_0015, 1'b1, 5'd14, 32'hC0DE_0003);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("full_pop1", bus.rf_wb_data, 32'hC0DE_0001);
    idle(1);
    chk("full_pop2", bus.rf_wb_data, 32'hC0DE_0002);
    idle(1);
    chk("full_no_third", 32'(bus.rf_wb_en), 32'd0);

    // x0 targets are consumed without a write.
    step(1'b1, 5'd0, 32'hFFFF_0000, 1'b0, 5'd0, 32'd0);
    chk("p_x0_en", 32'(bus.rf_wb_en), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hEEEE_0000);
    idle(1);
    chk("m_x0_en", 32'(bus.rf_wb_en), 32'd0);
    idle(1);
    chk("m_x0_consumed", 32'(bus.m_ready), 32'd1);

    // Reset in the middle of the sweep.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1; rst = 1'b1; model_reset(); #1; rst = 1'b0;  // short pulse between edges
    idle(11);
    chk("sweep_at10", 32'(bus.rf_rd_index), 32'd10);
    async_reset("mid_sweep");
    idle(1);
    chk("resweep_idx0", 32'(bus.rf_rd_index), 32'd0);
    idle(31);

    // Reset with two entries queued; they must never reach the write port.
    step(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd4, 32'hBAD0_0004);
    step(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd6, 32'hBAD0_0006);
    chk("occ2_ready", 32'(bus.m_ready), 32'd0);
    async_reset("occ2");
    idle(32);
    idle(3);
    chk("no_stale_en", 32'(bus.rf_wb_en), 32'd0);

    // Randomized traffic; some windows keep the pipeline nearly always busy.
    hold = 1'b0;
    pw = 1'b0; prd = 5'd0; pd = 32'd0;
    for (int c = 0; c < 1500; c++) begin
      if (!(hold && pw)) begin
        if (((c / 100) % 3) == 0) pw = ($urandom_range(0, 99) < 95);
        else                      pw = ($urandom_range(0, 99) < 50);
        prd = 5'($urandom_range(0, 31));
        pd  = $urandom;
      end
      step(pw, prd, pd, ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom);
      hold = (mode != M_RUN);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
